// File: rtl/pcm_frame_packetizer_pkg.sv
// Shared definitions for the PCM frame packetizer: frame byte states and
// the constants used on the sample and byte-stream sides.
package pcm_frame_packetizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam int         SAMPLE_W          = 16;

    // Width of a counter indexing n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// First-word-fall-through synchronous FIFO: array storage with a registered
// read port that prefetches the next head, plus registered full/empty/count.
module pcm_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_addr_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             push;
    logic             pop;

    assign push         = wr_en & ~full_reg;
    assign pop          = rd_en & ~empty_reg;
    assign rd_addr_next = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_addr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == FULL_CNT);
            empty_reg  <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The next head is read one cycle ahead; when the word being written is
    // itself the next head (FIFO draining to one entry), forward it directly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_reg <= '0;
        end else if (push && (wr_ptr_reg == rd_addr_next)) begin
            rd_data_reg <= wr_data;
        end else begin
            rd_data_reg <= mem[rd_addr_next];
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/pcm_frame_packetizer.sv
// Buffers decimated PCM samples and emits fixed-length byte frames:
// sync byte, sequence number, then each sample MSB first.
module pcm_frame_packetizer
    import pcm_frame_packetizer_pkg::*;
#(
    parameter int         FIFO_DEPTH        = 64,
    parameter int         SAMPLES_PER_FRAME = 16,
    parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic [1:0]  in_error,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic [15:0] err_drop_cnt
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              IW        = idx_width(SAMPLES_PER_FRAME);
    localparam logic [AW:0]     FRAME_CNT = (AW + 1)'(SAMPLES_PER_FRAME);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(SAMPLES_PER_FRAME - 1);

    frame_state_t          state_reg;
    frame_state_t          state_next;
    logic [SAMPLE_W-1:0]   sample_reg;
    logic [SAMPLE_W-1:0]   sample_next;
    logic [IW-1:0]         idx_reg;
    logic [IW-1:0]         idx_next;
    logic [7:0]            seq_reg;
    logic [7:0]            seq_next;

    logic [7:0]            out_data_reg;
    logic [7:0]            out_data_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic                  out_sop_reg;
    logic                  out_sop_next;
    logic                  out_eop_reg;
    logic                  out_eop_next;
    logic                  overflow_reg;
    logic [15:0]           err_cnt_reg;

    logic                  sample_ok;
    logic                  drop_full;
    logic                  drop_err;
    logic                  fifo_wr;
    logic                  pop_req;
    logic [SAMPLE_W-1:0]   fifo_rd_data;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  frame_ready;

    assign sample_ok   = in_valid & (in_error == ERR_NONE);
    assign fifo_wr     = sample_ok & ~fifo_full;
    assign drop_full   = sample_ok & fifo_full;
    assign drop_err    = in_valid & (in_error != ERR_NONE);
    assign accept      = out_valid_reg & out_ready;
    assign frame_ready = (fifo_count >= FRAME_CNT);

    pcm_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (pop_req & ~fifo_empty),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // state_reg names the byte currently presented on the output registers.
    always_comb begin
        state_next  = state_reg;
        sample_next = sample_reg;
        idx_next    = idx_reg;
        seq_next    = seq_reg;
        pop_req     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (accept) begin
                    state_next = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (accept) begin
                    state_next  = ST_HI;
                    pop_req     = 1'b1;
                    sample_next = fifo_rd_data;
                    idx_next    = '0;
                end
            end
            ST_HI: begin
                if (accept) begin
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    if (idx_reg == LAST_IDX) begin
                        seq_next   = seq_reg + 8'd1;
                        state_next = frame_ready ? ST_SYNC : ST_IDLE;
                    end else begin
                        pop_req     = 1'b1;
                        sample_next = fifo_rd_data;
                        idx_next    = idx_reg + IW'(1);
                        state_next  = ST_HI;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they register alongside it
    // and hold naturally while the consumer stalls.
    always_comb begin
        out_valid_next = (state_next != ST_IDLE);
        out_sop_next   = (state_next == ST_SYNC);
        out_eop_next   = (state_next == ST_LO) && (idx_next == LAST_IDX);
        out_data_next  = '0;
        case (state_next)
            ST_SYNC: out_data_next = SYNC_BYTE;
            ST_SEQ:  out_data_next = seq_next;
            ST_HI:   out_data_next = sample_next[15:8];
            ST_LO:   out_data_next = sample_next[7:0];
            default: out_data_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            sample_reg    <= '0;
            idx_reg       <= '0;
            seq_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sample_reg    <= sample_next;
            idx_reg       <= idx_next;
            seq_reg       <= seq_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_sop_reg   <= out_sop_next;
            out_eop_reg   <= out_eop_next;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            if (drop_full) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
            if (drop_err && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign out_data     = out_data_reg;
    assign out_valid    = out_valid_reg;
    assign out_sop      = out_sop_reg;
    assign out_eop      = out_eop_reg;
    assign overflow     = overflow_reg;
    assign err_drop_cnt = err_cnt_reg;

endmodule

// File: tb/tb_pcm_frame_packetizer.sv
// Self-checking bench for pcm_frame_packetizer: a model builds expected frame
// bytes as samples are driven and a monitor compares each accepted byte.
module tb_pcm_frame_packetizer;
    localparam int         SPF  = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_error = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [15:0] err_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pcm_frame_packetizer #(
        .FIFO_DEPTH        (64),
        .SAMPLES_PER_FRAME (SPF),
        .SYNC_BYTE         (SYNC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_error       (in_error),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .err_drop_cnt   (err_drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // out_ready: 0 = low, 1 = high, 2 = toggle each cycle, 3 = ready_man
    int   ready_mode = 0;
    logic ready_man  = 1'b0;
    logic tog        = 1'b0;
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = tog;
            3:       out_ready = ready_man;
            default: out_ready = 1'b0;
        endcase
    end

    // Expected byte entries are {sop, eop, data}.
    logic [9:0]  exp_q[$];
    logic [15:0] pend[$];
    logic [7:0]  exp_seq = '0;
    int          exp_err = 0;

    task automatic model_store(input logic [15:0] s);
        logic [15:0] v;
        pend.push_back(s);
        if (pend.size() == SPF) begin
            exp_q.push_back({2'b10, SYNC});
            exp_q.push_back({2'b00, exp_seq});
            for (int i = 0; i < SPF; i++) begin
                v = pend[i];
                exp_q.push_back({2'b00, v[15:8]});
                exp_q.push_back({1'b0, (i == SPF - 1), v[7:0]});
            end
            pend.delete();
            exp_seq++;
        end
    endtask

    task automatic push_sample(input logic [15:0] d, input logic [1:0] e,
                               input bit store, input bit clr, input int gap);
        @(posedge clk);
        #1;
        in_data = d;
        in_valid = 1'b1;
        in_error = e;
        clear_overflow = clr;
        if (e != 2'b00) begin
            if (exp_err < 65535) exp_err++;
        end else if (store) begin
            model_store(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_error = '0;
        clear_overflow = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    bit         mon_en = 1'b0;
    bit         hold_pend = 1'b0;
    logic [9:0] held;
    logic [9:0] exp_b;
    int         frames_rx = 0;
    int         byte_pos = 0;
    logic [7:0] rx_seq;

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (out_valid) begin
                if (hold_pend) check_eq("stall_hold", {out_sop, out_eop, out_data}, held);
                if (out_ready) begin
                    hold_pend = 1'b0;
                    check_eq("exp_avail", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check_eq("byte", {out_sop, out_eop, out_data}, exp_b);
                    end
                    if (out_sop) byte_pos = 0;
                    if (byte_pos == 1) rx_seq = out_data;
                    byte_pos++;
                    if (out_eop) begin
                        frames_rx++;
                        $display("rx frame %0d seq %02h bytes %0d", frames_rx, rx_seq, byte_pos);
                    end
                end else begin
                    hold_pend = 1'b1;
                    held = {out_sop, out_eop, out_data};
                end
            end else begin
                if (hold_pend) check_eq("valid_held", out_valid, 1);
                hold_pend = 1'b0;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        mon_en = 1'b0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        pend.delete();
        exp_seq = '0;
        exp_err = 0;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sop", out_sop, 0);
        check_eq("rst_eop", out_eop, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_err_cnt", err_drop_cnt, 0);
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_left", exp_q.size(), 0);
        @(negedge clk);
        check_eq("idle_valid", out_valid, 0);
    endtask

    initial begin
        int f0;
        int n;
        reset_dut();

        // single frame, one sample per 4 cycles
        ready_mode = 1;
        for (int i = 1; i <= 16; i++) push_sample(16'(i), 2'b00, 1'b1, 1'b0, 2);
        wait_drain(300);

        // three frames with a toggling consumer
        @(negedge clk);
        ready_mode = 2;
        for (int i = 0; i < 48; i++) push_sample(16'h1000 + 16'(i), 2'b00, 1'b1, 1'b0, 2);
        wait_drain(1000);

        // overflow with consumer stalled
        @(negedge clk);
        ready_mode = 0;
        for (int i = 0; i < 70; i++) begin
            push_sample(16'h2000 + 16'(i), 2'b00, (i < 64), 1'b0, 0);
            if (i == 63) check_eq("ovf_before", overflow, 0);
            if (i == 64) check_eq("ovf_set", overflow, 1);
        end
        push_sample(16'h2FFF, 2'b00, 1'b0, 1'b1, 0);
        check_eq("ovf_set_wins", overflow, 1);
        @(posedge clk);
        #1 clear_overflow = 1'b1;
        @(posedge clk);
        #1 clear_overflow = 1'b0;
        check_eq("ovf_cleared", overflow, 0);
        @(negedge clk);
        ready_mode = 1;
        wait_drain(500);

        // error-coded samples are discarded
        for (int i = 0; i < 18; i++) begin
            if (i == 5) push_sample(16'hDEAD, 2'b01, 1'b1, 1'b0, 1);
            else if (i == 11) push_sample(16'hBEEF, 2'b01, 1'b1, 1'b0, 1);
            else push_sample(16'($urandom), 2'b00, 1'b1, 1'b0, 1);
        end
        check_eq("err_drop_cnt", err_drop_cnt, 32'(exp_err));
        check_eq("err_drop_two", err_drop_cnt, 2);
        wait_drain(300);

        // sequence number wrap over 257 frames
        reset_dut();
        ready_mode = 1;
        f0 = frames_rx;
        for (int i = 0; i < 257 * SPF; i++) push_sample(16'($urandom), 2'b00, 1'b1, 1'b0, 1);
        wait_drain(2000);
        check_eq("frames_257", frames_rx - f0, 257);

        // reset during the HI byte of sample 5
        @(negedge clk);
        ready_man = 1'b0;
        ready_mode = 3;
        for (int i = 1; i <= 16; i++) push_sample({8'(i), 8'h5A}, 2'b00, 1'b1, 1'b0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        check_eq("t6_start", out_valid, 1);
        ready_man = 1'b1;
        repeat (10) @(negedge clk);
        ready_man = 1'b0;
        @(negedge clk);
        check_eq("t6_hi5", {out_valid, out_sop, out_eop, out_data}, {3'b100, 8'h05});
        reset_dut();
        ready_mode = 1;
        for (int i = 0; i < 16; i++) push_sample(16'h7700 + 16'(i), 2'b00, 1'b1, 1'b0, 0);
        wait_drain(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(900_000);
        n_errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
